spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_slave_rx_sync_ff.sv | 27 ++
 rtl/spi_slave_rx.sv | 164 ++++++++++++++++
 tb/tb_spi_slave_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver: FSM state encoding and default word width.
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input, with a configurable reset level.
module sync_ff
    import spi_pkg::*;
#(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    // Shift the raw input through DEPTH flops; reset to the line's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {DEPTH{RST_VAL}};
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled sclk/cs_n/mosi, MSB-first receive and transmit,
// one-word TX holding register, back-to-back words under one chip select.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    spi_state_e state;

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_p1, cs_n_p1;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_full;
    logic                  word_done;
    logic                  tx_load;
    logic                  tx_accept;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk_i),
        .q     (sclk_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs_n_i),
        .q     (cs_n_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mosi_i),
        .q     (mosi_s)
    );

    // One-cycle delayed copies of the synchronized sclk and cs_n for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_p1 <= 1'b0;
            cs_n_p1 <= 1'b1;
        end else begin
            sclk_p1 <= sclk_s;
            cs_n_p1 <= cs_n_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_p1;
    assign sclk_fall = ~sclk_s & sclk_p1;
    assign cs_fall   = ~cs_n_s & cs_n_p1;
    assign cs_rise   = cs_n_s & ~cs_n_p1;

    assign rx_next   = {rx_sr[DATA_WIDTH-2:0], mosi_s};
    // A word completes on the last rising edge unless the master deselects in the same cycle.
    assign word_done = (state == SHIFT) && !cs_rise && sclk_rise && (cnt == LAST_BIT);
    assign tx_load   = ((state == IDLE) && cs_fall) || word_done;
    assign tx_accept = tx_valid && !hold_full;

    assign tx_ready  = ~hold_full;
    assign miso_o    = tx_sr[DATA_WIDTH-1];

    // Holding register occupancy: an accept always wins, since a load can only empty a full register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
        end else if (tx_accept) begin
            hold_full <= 1'b1;
        end else if (tx_load) begin
            hold_full <= 1'b0;
        end
    end

    // Holding register payload; qualified by hold_full so it needs no reset.
    always_ff @(posedge clk) begin
        if (tx_accept) begin
            hold_data <= tx_data;
        end
    end

    // Transfer FSM with registered status outputs, bit counter and both shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            miso_oe     <= 1'b0;
            cnt         <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        miso_oe <= 1'b1;
                        cnt     <= '0;
                        rx_sr   <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        // Deselect drops any partial word and unsent TX bits.
                        state   <= IDLE;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                        cnt     <= '0;
                        tx_sr   <= '0;
                    end else if (sclk_rise) begin
                        rx_sr <= rx_next;
                        if (cnt == LAST_BIT) begin
                            cnt      <= '0;
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (sclk_fall && (cnt != '0)) begin
                        // The falling edge right after a word boundary must not shift the freshly loaded word.
                        tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
            if (tx_load) begin
                tx_sr       <= hold_full ? hold_data : '0;
                tx_underrun <= ~hold_full;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a bit-level SPI master, a word-level receive model
// checked every clock, and hand-computed expectations for each scenario.
module tb_spi_slave_rx;

    localparam int W    = 8;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sclk_i = 1'b0;
    logic         cs_n_i = 1'b1;
    logic         mosi_i = 1'b0;
    logic         miso_o, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic [W-1:0] rx_data;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int un_cnt   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_rx = '0;

    spi_slave_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_i      (sclk_i),
        .cs_n_i      (cs_n_i),
        .mosi_i      (mosi_i),
        .miso_o      (miso_o),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Receive model: every completed word the master sent must appear once, in order; rx_data holds otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_valid_unexpected: got pulse with rx_data 0x%02h, expected no pulse", rx_data);
                end else begin
                    model_rx = exp_q.pop_front();
                    check_byte("rx_data_on_valid", rx_data, model_rx);
                end
            end else begin
                check_byte("rx_data_held", rx_data, model_rx);
            end
            if (tx_underrun) un_cnt++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [W-1:0] w);
        int t = 0;
        @(negedge clk);
        while (!tx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_tx_timeout: tx_ready still %b after %0d cycles, expected 1", tx_ready, t);
        end
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_start();
        cs_n_i = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_end();
        cs_n_i = 1'b1;
        wait_clks(HALF);
    endtask

    // Mode-0 master: drive mosi while sclk is low, sample miso just before the rising edge.
    task automatic xfer(input logic [W-1:0] w, input int nb, output logic [W-1:0] m);
        m = '0;
        if (nb == W) exp_q.push_back(w);
        for (int i = 0; i < nb; i++) begin
            mosi_i = w[W-1-i];
            wait_clks(HALF);
            m[W-1-i] = miso_o;
            sclk_i = 1'b1;
            wait_clks(HALF);
            sclk_i = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_miso_o"}, miso_o, 1'b0);
        check_bit({tag, "_miso_oe"}, miso_oe, 1'b0);
        check_bit({tag, "_tx_ready"}, tx_ready, 1'b1);
        check_byte({tag, "_rx_data"}, rx_data, 8'h00);
        check_bit({tag, "_rx_valid"}, rx_valid, 1'b0);
        check_bit({tag, "_tx_underrun"}, tx_underrun, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] m1, m2;
        int rx0, un0;

        #1;
        check_reset_outputs("por");
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4);

        // Single word: A5 out, 3C in.
        push_tx(8'hA5);
        check_bit("hold_full_after_push", tx_ready, 1'b0);
        rx0 = rx_cnt; un0 = un_cnt;
        cs_start();
        check_bit("single_busy", busy, 1'b1);
        check_bit("single_miso_oe", miso_oe, 1'b1);
        check_bit("single_hold_emptied", tx_ready, 1'b1);
        check_bit("single_first_miso", miso_o, 1'b1);
        push_tx(8'h00);
        xfer(8'h3C, W, m1);
        cs_end();
        check_byte("single_miso_word", m1, 8'hA5);
        check_byte("single_rx_data", rx_data, 8'h3C);
        check_int("single_rx_pulses", rx_cnt - rx0, 1);
        check_int("single_underruns", un_cnt - un0, 0);
        check_bit("single_busy_after", busy, 1'b0);
        check_bit("single_miso_oe_after", miso_oe, 1'b0);

        // Back-to-back words: 81, 7E in; 55, AA out.
        push_tx(8'h55);
        rx0 = rx_cnt; un0 = un_cnt;
        cs_start();
        push_tx(8'hAA);
        xfer(8'h81, W, m1);
        push_tx(8'h5A);
        xfer(8'h7E, W, m2);
        cs_end();
        check_byte("b2b_miso_word0", m1, 8'h55);
        check_byte("b2b_miso_word1", m2, 8'hAA);
        check_int("b2b_rx_pulses", rx_cnt - rx0, 2);
        check_byte("b2b_rx_data", rx_data, 8'h7E);
        check_int("b2b_underruns", un_cnt - un0, 0);

        // Underrun at chip select: MISO all zeros, exactly one pulse.
        rx0 = rx_cnt; un0 = un_cnt;
        cs_start();
        push_tx(8'hC3);
        xfer(8'h3C, W, m1);
        cs_end();
        check_byte("underrun_miso_word", m1, 8'h00);
        check_int("underrun_pulses", un_cnt - un0, 1);
        check_byte("underrun_rx_data", rx_data, 8'h3C);

        // Abort after 5 of 8 bits, then a full word.
        rx0 = rx_cnt;
        cs_start();
        xfer(8'hFF, 5, m1);
        cs_end();
        check_int("abort_rx_pulses", rx_cnt - rx0, 0);
        check_byte("abort_rx_data_kept", rx_data, 8'h3C);
        push_tx(8'h96);
        rx0 = rx_cnt;
        cs_start();
        push_tx(8'h00);
        xfer(8'hF0, W, m1);
        cs_end();
        check_byte("after_abort_miso_word", m1, 8'h96);
        check_byte("after_abort_rx_data", rx_data, 8'hF0);
        check_int("after_abort_rx_pulses", rx_cnt - rx0, 1);

        // Reset after 3 bits, with the holding register full.
        cs_start();
        push_tx(8'h22);
        xfer(8'h55, 3, m1);
        check_bit("pre_reset_hold_full", tx_ready, 1'b0);
        @(posedge clk);
        #2;
        model_rx = '0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midword_rst");
        cs_n_i = 1'b1;
        wait_clks(4);
        rst_n = 1'b1;
        rx0 = rx_cnt;
        wait_clks(40);
        check_int("post_reset_rx_pulses", rx_cnt - rx0, 0);
        check_byte("post_reset_rx_data", rx_data, 8'h00);
        check_bit("post_reset_busy", busy, 1'b0);

        // sclk activity while deselected.
        rx0 = rx_cnt;
        for (int i = 0; i < W; i++) begin
            mosi_i = i[0];
            sclk_i = 1'b1;
            wait_clks(HALF);
            check_bit("idle_sclk_busy", busy, 1'b0);
            check_bit("idle_sclk_miso_oe", miso_oe, 1'b0);
            sclk_i = 1'b0;
            wait_clks(HALF);
        end
        check_int("idle_sclk_rx_pulses", rx_cnt - rx0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
